// File: rtl/input_deserializer_pkg.sv
// Shared device configuration for the input deserializer: bus and sample geometry.
package input_deserializer_pkg;

  localparam int unsigned CFG_INPUT_BUS_WIDTH = 64;
  localparam int unsigned CFG_INPUT_SIZE_BITS = 784;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  localparam int unsigned CFG_SAMPLE_BUS_CYCLES = ceil_div(CFG_INPUT_SIZE_BITS, CFG_INPUT_BUS_WIDTH);

endpackage

// File: rtl/input_deserializer.sv
// Assembles INPUT_SIZE_BITS-wide samples from INPUT_BUS_WIDTH-wide beats, with a
// separate output holding register so assembly of the next sample never stalls early.
module input_deserializer
  import input_deserializer_pkg::*;
#(
  parameter int INPUT_BUS_WIDTH = int'(CFG_INPUT_BUS_WIDTH),
  parameter int INPUT_SIZE_BITS = int'(CFG_INPUT_SIZE_BITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inp_vld,
  input  logic [INPUT_BUS_WIDTH-1:0] inp,
  output logic                       stall,
  output logic                       sample_vld,
  output logic [INPUT_SIZE_BITS-1:0] sample,
  input  logic                       sample_rdy,
  output logic [31:0]                sample_count
);

  localparam int unsigned IBW    = unsigned'(INPUT_BUS_WIDTH);
  localparam int unsigned ISB    = unsigned'(INPUT_SIZE_BITS);
  localparam int unsigned SBC    = ceil_div(ISB, IBW);
  localparam int unsigned CNT_W  = (SBC > 1) ? $clog2(SBC) : 1;
  localparam int unsigned LAST_W = ISB - (SBC - 1) * IBW;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SBC - 1);

  if (INPUT_BUS_WIDTH < 1 || INPUT_SIZE_BITS < 1) begin : g_param_chk
    $error("input_deserializer: INPUT_BUS_WIDTH and INPUT_SIZE_BITS must be >= 1");
  end

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             out_full_q, out_full_d;
  logic [ISB-1:0]   sample_q, sample_d;
  logic [31:0]      count_q, count_d;

  logic             last_c;
  logic             xfer_c;
  logic             consume_c;
  logic [ISB-1:0]   full_c;

  assign last_c    = (beat_cnt_q == LAST);
  assign stall     = rst | (last_c & out_full_q & ~sample_rdy);
  assign xfer_c    = inp_vld & ~stall;
  assign consume_c = out_full_q & sample_rdy;

  // Beats 0..last-1 live in the assembly register; the last beat bypasses it.
  if (SBC > 1) begin : g_asm
    localparam int unsigned ASM_W = (SBC - 1) * IBW;
    logic [ASM_W-1:0] asm_q, asm_d;

    always_comb begin
      asm_d = asm_q;
      if (xfer_c && !last_c) begin
        asm_d[32'(beat_cnt_q) * IBW +: IBW] = inp;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) asm_q <= '0;
      else     asm_q <= asm_d;
    end

    assign full_c = {inp[LAST_W-1:0], asm_q};
  end else begin : g_single
    assign full_c = inp[LAST_W-1:0];
  end

  // Padding bits of the final beat are deliberately dropped.
  if (LAST_W < IBW) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^inp[IBW-1:LAST_W];
  end

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    out_full_d = out_full_q;
    sample_d   = sample_q;
    count_d    = count_q;
    if (consume_c) begin
      out_full_d = 1'b0;
      count_d    = count_q + 32'd1;
    end
    if (xfer_c) begin
      beat_cnt_d = last_c ? '0 : beat_cnt_q + CNT_W'(1);
      if (last_c) begin
        sample_d   = full_c;
        out_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      out_full_q <= 1'b0;
      sample_q   <= '0;
      count_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      out_full_q <= out_full_d;
      sample_q   <= sample_d;
      count_q    <= count_d;
    end
  end

  assign sample_vld   = out_full_q;
  assign sample       = sample_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_input_deserializer.sv
// Bench for input_deserializer: queue-based sample model plus directed and random traffic.
module tb_input_deserializer;

  localparam int IBW = 64;
  localparam int ISB = 784;
  localparam int SBC = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            inp_vld, stall, sample_vld, sample_rdy;
  logic [IBW-1:0]  inp;
  logic [ISB-1:0]  sample;
  logic [31:0]     sample_count;

  logic            inp_vld8, stall8, sample_vld8, sample_rdy8;
  logic [7:0]      inp8, sample8;
  logic [31:0]     sample_count8;

  input_deserializer dut (
    .clk(clk), .rst(rst), .inp_vld(inp_vld), .inp(inp), .stall(stall),
    .sample_vld(sample_vld), .sample(sample), .sample_rdy(sample_rdy),
    .sample_count(sample_count)
  );

  input_deserializer #(.INPUT_BUS_WIDTH(8), .INPUT_SIZE_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .inp_vld(inp_vld8), .inp(inp8), .stall(stall8),
    .sample_vld(sample_vld8), .sample(sample8), .sample_rdy(sample_rdy8),
    .sample_count(sample_count8)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [ISB-1:0] act, input logic [ISB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: accepted beats since reset, grouped into samples of SBC beats.
  logic [IBW-1:0] beats[$];
  logic [ISB-1:0] expq[$];
  int unsigned    mcount = 0;
  int             cyc = 0;
  bit             armed = 0;
  int             vld_rise[$];
  bit             prev_vld = 0;

  function automatic bit exp_stall_f();
    return rst || (beats.size() == SBC - 1 && expq.size() != 0 && !sample_rdy);
  endfunction

  always @(posedge clk) begin
    logic [SBC*IBW-1:0] w;
    bit st;
    cyc++;
    st = exp_stall_f();
    if (rst) begin
      armed = 1;
      beats.delete();
      expq.delete();
      mcount = 0;
    end else if (armed) begin
      if (expq.size() != 0 && sample_rdy) begin
        void'(expq.pop_front());
        mcount++;
      end
      if (inp_vld && !st) begin
        beats.push_back(inp);
        if (beats.size() == SBC) begin
          w = '0;
          foreach (beats[k]) w[k*IBW +: IBW] = beats[k];
          expq.push_back(w[ISB-1:0]);
          beats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("stall", stall, exp_stall_f());
      chk("sample_vld", sample_vld, expq.size() != 0);
      if (expq.size() != 0) chk("sample", sample, expq[0]);
      chk("sample_count", sample_count, mcount);
      if (sample_vld && !prev_vld) vld_rise.push_back(cyc);
      prev_vld = sample_vld;
    end
  end

  // Single-beat configuration model: every accepted beat is a full sample.
  bit          full8 = 0;
  logic [7:0]  val8 = '0;
  int unsigned cnt8 = 0;

  always @(posedge clk) begin
    bit st8;
    st8 = rst || (full8 && !sample_rdy8);
    if (rst) begin
      full8 = 0;
      cnt8  = 0;
    end else if (armed) begin
      if (full8 && sample_rdy8) begin
        full8 = 0;
        cnt8++;
      end
      if (inp_vld8 && !st8) begin
        full8 = 1;
        val8  = inp8;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("stall8", stall8, rst || (full8 && !sample_rdy8));
      chk("sample_vld8", sample_vld8, full8);
      if (full8) chk("sample8", sample8, val8);
      chk("sample_count8", sample_count8, cnt8);
    end
  end

  initial begin
    inp_vld8 = 1'b0;
    inp8 = '0;
    sample_rdy8 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sample_rdy8 = ~sample_rdy8;
      inp_vld8 = ($urandom % 4) != 0;
      inp8 = 8'($urandom);
    end
  end

  // Presents one beat until accepted; reports how many cycles it was stalled.
  task automatic send(input logic [IBW-1:0] d, output int waits);
    waits = 0;
    inp_vld = 1'b1;
    inp = d;
    @(negedge clk);
    while (stall && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (stall) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got stall=1 after %0d cycles expected accept", waits);
    end
    @(posedge clk);
    #1;
    inp_vld = 1'b0;
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!sample_vld && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!sample_vld) begin
      tests++;
      fails++;
      $display("FAIL wait_vld_timeout: got sample_vld=0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    int c, w, wsum;
    logic [IBW-1:0] lit;
    inp_vld = 1'b0;
    inp = '0;
    sample_rdy = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_vld", sample_vld, 1'b0);
    chk("reset_count", sample_count, 32'd0);
    chk("reset_sample", sample, '0);

    // Three samples back-to-back with downstream always ready.
    c = cyc;
    vld_rise.delete();
    wsum = 0;
    for (int i = 0; i < 3 * SBC; i++) begin
      send({$urandom, $urandom}, w);
      wsum += w;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("a_no_stall", wsum, 0);
    chk("a_pulses", vld_rise.size(), 3);
    if (vld_rise.size() == 3) begin
      chk("a_first", vld_rise[0] - c, 13);
      chk("a_gap13", vld_rise[1] - vld_rise[0], 13);
      chk("a_gap26", vld_rise[2] - vld_rise[0], 26);
    end
    chk("a_count", sample_count, 32'd3);

    // Downstream blocked: only the last beat of the second sample stalls.
    sample_rdy = 1'b0;
    wsum = 0;
    for (int i = 0; i < 2 * SBC - 1; i++) begin
      send({$urandom, $urandom}, w);
      wsum += w;
    end
    chk("b_no_early_stall", wsum, 0);
    inp_vld = 1'b1;
    inp = {$urandom, $urandom};
    repeat (3) begin
      @(negedge clk);
      chk("b_stall", stall, 1'b1);
    end
    @(posedge clk);
    #1;
    sample_rdy = 1'b1;
    @(negedge clk);
    chk("b_accept", stall, 1'b0);
    @(posedge clk);
    #1;
    inp_vld = 1'b0;
    @(negedge clk);
    chk("b_vld_held", sample_vld, 1'b1);
    chk("b_count", sample_count, 32'd4);
    @(posedge clk);
    #1;

    // Padding on the final beat: all-ones, then X.
    sample_rdy = 1'b0;
    for (int k = 0; k < SBC; k++) begin
      if (k == 0) lit = 64'h0123_4567_89AB_CDEF;
      else if (k == 11) lit = 64'hDEAD_BEEF_CAFE_F00D;
      else if (k == 12) lit = {48'hFFFF_FFFF_FFFF, 16'h1234};
      else lit = {$urandom, $urandom};
      send(lit, w);
    end
    wait_vld();
    chk("c_beat0", sample[63:0], 64'h0123_4567_89AB_CDEF);
    chk("c_beat11", sample[767:704], 64'hDEAD_BEEF_CAFE_F00D);
    chk("c_pad_ones", sample[783:768], 16'h1234);
    for (int k = 0; k < SBC - 1; k++) send({$urandom, $urandom}, w);
    sample_rdy = 1'b1;
    send({48'bx, 16'hBEEF}, w);
    sample_rdy = 1'b0;
    @(negedge clk);
    chk("c_pad_x", sample[783:768], 16'hBEEF);
    chk("c_no_x", (^sample) === 1'bx, 1'b0);
    @(posedge clk);
    #1;
    sample_rdy = 1'b1;
    @(posedge clk);
    #1;

    // inp_vld alternating every cycle.
    c = cyc;
    vld_rise.delete();
    for (int k = 0; k < SBC; k++) begin
      send({$urandom, $urandom}, w);
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("d_pulses", vld_rise.size(), 1);
    if (vld_rise.size() == 1) chk("d_latency", vld_rise[0] - c, 25);

    // Reset in the middle of a sample discards the partial beats.
    for (int k = 0; k < 5; k++) send({$urandom, $urandom}, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("e_count0", sample_count, 32'd0);
    chk("e_vld0", sample_vld, 1'b0);
    for (int k = 0; k < SBC; k++) send({$urandom, $urandom}, w);
    repeat (2) @(posedge clk);
    #1;
    chk("e_count1", sample_count, 32'd1);

    // Random traffic and backpressure.
    repeat (400) begin
      inp_vld = ($urandom % 10) < 7;
      inp = {$urandom, $urandom};
      sample_rdy = ($urandom % 10) < 6;
      @(posedge clk);
      #1;
    end
    inp_vld = 1'b0;
    sample_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
